instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, giving the number of prefetch buffer entries (legal values 2 or 4).
REQ-002 The module SHALL have parameter RESET_PC, default 8'h00, giving the first fetch address after reset.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 LoadIRSig  input  1  CPU pop request; consumes the head instruction when instr_valid=1.
REQ-006 instruction  output  8  head-of-buffer instruction byte presented to the CPU IR.
REQ-007 instr_valid  output  1  instruction holds a valid byte.
REQ-008 jump  input  1  one-cycle redirect strobe.
REQ-009 jump_addr  input  8  redirect target, sampled when jump=1.
REQ-010 pc  output  8  address of the byte currently on instruction.
REQ-011 mem_req  output  1  memory read request, held until acknowledged.
REQ-012 mem_addr  output  8  read address, stable while mem_req=1.
REQ-013 mem_ack  input  1  one-cycle acknowledge; mem_data is valid in the same cycle.
REQ-014 mem_data  input  8  read data from instruction memory.

Function
REQ-015 The FSM SHALL have three states: IDLE (no request outstanding), WAIT (request outstanding), and DISCARD (request outstanding whose data is stale).
REQ-016 IDLE->WAIT SHALL occur when buffer count < DEPTH and jump=0; mem_req rises in the next cycle with mem_addr=fetch_ptr.
REQ-017 WAIT with mem_ack=1 and jump=0 SHALL push mem_data, increment fetch_ptr mod 256 (8'hFF->8'h00), and go to WAIT again if count after push and pop < DEPTH, otherwise to IDLE.
REQ-018 mem_req SHALL fall in the cycle after mem_ack; it SHALL never be asserted in the same cycle as an ack.
REQ-019 At most one request SHALL be outstanding; no push SHALL ever occur while the buffer is full.
REQ-020 instruction SHALL equal the buffer head, and instr_valid SHALL be 1 whenever count>0; the latency from mem_ack to instr_valid, with an empty buffer, SHALL be 1 cycle.
REQ-021 LoadIRSig=1 with instr_valid=1 SHALL pop the head and increment pc mod 256; LoadIRSig with instr_valid=0 SHALL be ignored.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and preserve byte order.
REQ-023 jump=1 SHALL flush the buffer (count=0), set pc and fetch_ptr to jump_addr, and take priority over a same-cycle pop and push.
REQ-024 jump=1 in WAIT SHALL go to DISCARD; in DISCARD, mem_ack SHALL drop mem_data without a push and return to IDLE.
REQ-025 jump=1 in DISCARD SHALL update fetch_ptr and pc only and remain in DISCARD.
REQ-026 jump=1 in the same cycle as mem_ack in WAIT SHALL drop mem_data and go to IDLE.
REQ-027 mem_addr SHALL not change while mem_req=1, including across a jump.

Reset
REQ-028 While reset=0, the block SHALL immediately and asynchronously set state=IDLE, count=0, instr_valid=0, instruction=8'h00, mem_req=0, mem_addr=RESET_PC, pc=RESET_PC, and fetch_ptr=RESET_PC.
REQ-029 A reset asserted mid-request SHALL abandon that request; a mem_ack arriving after reset release with no request outstanding SHALL be ignored.
REQ-030 The first mem_req after reset release SHALL assert in the 2nd rising edge after release, with mem_addr=RESET_PC.

Verification
REQ-031 Reset release, memory acks every request 1 cycle later with data=addr+8'h10, LoadIRSig=0 -> requests to 00 and 01 only; buffer holds 10,11; mem_req stays 0; pc=00.
REQ-032 Continuous LoadIRSig=1 with zero-wait memory -> CPU receives 10,11,12,... in order with no gaps or duplicates after the fill; pc tracks each byte.
REQ-033 Start fetching from 8'hFE -> mem_addr sequence FE,FF,00,01; pc wraps FF->00.
REQ-034 jump=1, jump_addr=8'h40 while a request to 03 is outstanding (ack 3 cycles later) -> the 03 data is dropped, instr_valid=0 until data from 40 arrives, next mem_addr=40, pc=40.
REQ-035 Buffer full while the CPU pops and the memory acks in the same cycle -> count stays DEPTH-1..DEPTH, no overflow, order preserved.
REQ-036 reset=0 pulse, asynchronous to clk, during WAIT -> all outputs reach their reset values before the next edge; a late mem_ack produces no push.

Source files
------------

// File: rtl/instr_fetch.sv
// Prefetch unit: one memory read outstanding, DEPTH-entry byte buffer feeding the CPU IR.
// Latency mem_ack -> instr_valid is 1 cycle; fetching pauses while the buffer is full.
module instr_fetch #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LoadIRSig,
  output logic [7:0] instruction,
  output logic       instr_valid,
  input  logic       jump,
  input  logic [7:0] jump_addr,
  output logic [7:0] pc,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t          state, stateNext;
  logic [7:0]      buffer [DEPTH];
  logic [PW-1:0]   rdPtr, wrPtr;
  logic [CW-1:0]   count, countAfter;
  logic [7:0]      fetchPtr;
  logic            ackValid, doPush, doPop, raiseReq;

  // An ack only counts against a request actually on the bus.
  assign ackValid    = mem_ack && mem_req;
  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? buffer[rdPtr] : 8'h00;
  assign doPop       = LoadIRSig && instr_valid && !jump;
  assign doPush      = (state == WAIT) && ackValid && !jump;
  assign countAfter  = count + CW'(doPush) - CW'(doPop);

  always_comb begin
    stateNext = state;
    raiseReq  = 1'b0;
    case (state)
      IDLE: begin
        if (!jump && count < DEPTH_C) stateNext = WAIT;
      end
      WAIT: begin
        if (ackValid) begin
          if (jump)                      stateNext = IDLE;
          else if (countAfter < DEPTH_C) stateNext = WAIT;
          else                           stateNext = IDLE;
        end else if (mem_req) begin
          if (jump) stateNext = DISCARD;
        end else if (!jump) begin
          // Request goes out the cycle after entering WAIT or after the previous ack.
          raiseReq = 1'b1;
        end
      end
      DISCARD: begin
        if (ackValid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetchPtr <= RESET_PC;
      pc       <= RESET_PC;
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
    end else begin
      state <= stateNext;

      if (raiseReq) begin
        mem_req  <= 1'b1;
        mem_addr <= fetchPtr;
      end else if (ackValid) begin
        mem_req  <= 1'b0;
      end

      if (jump)        fetchPtr <= jump_addr;
      else if (doPush) fetchPtr <= fetchPtr + 8'h01;

      if (jump)       pc <= jump_addr;
      else if (doPop) pc <= pc + 8'h01;

      if (jump) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        count <= countAfter;
        if (doPush) wrPtr <= wrPtr + PW'(1);
        if (doPop)  rdPtr <= rdPtr + PW'(1);
      end
    end
  end

  // Storage needs no reset: instruction is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (doPush) buffer[wrPtr] <= mem_data;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed cycle table, async-reset and wrap sequences, random run vs queue model.
module tb_instr_fetch;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       LoadIRSig = 1'b0;
  logic [7:0] instruction;
  logic       instr_valid;
  logic       jump = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic [7:0] pc;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_data = 8'h00;

  instr_fetch #(.DEPTH(D), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .LoadIRSig(LoadIRSig), .instruction(instruction),
    .instr_valid(instr_valid), .jump(jump), .jump_addr(jump_addr), .pc(pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int applied = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte queue, CPU pc, next fetch address, stale-request flag.
  logic [7:0] mq[$];
  logic [7:0] reqLog[$];
  logic [7:0] mPc, mFp, prevAddr;
  bit         mStale, prevReq;
  int         waitCnt, idleRun, popsSeen;

  task automatic modelInit();
    mq.delete();
    mPc = 8'h00; mFp = 8'h00; mStale = 0; prevReq = 0; prevAddr = 8'h00;
    waitCnt = 0; idleRun = 0;
  endtask

  task automatic doReset();
    reset = 1'b0; LoadIRSig = 0; jump = 0; jump_addr = 8'h00; mem_ack = 0; mem_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: check outputs against model, act as memory, drive inputs, advance model.
  task automatic step(input bit lp, input bit jmp, input logic [7:0] ja, input int maxDelay, input bit spur);
    bit req, ack, acc;
    logic [7:0] dat, expInstr;
    #1;
    req = mem_req;
    expInstr = 8'h00;
    if (mq.size() > 0) expInstr = mq[0];
    chk("valid", instr_valid, mq.size() > 0);
    chk("instr", instruction, expInstr);
    chk("pc", pc, mPc);
    ack = 0; dat = 8'h00;
    if (req) begin
      if (!prevReq) begin
        reqLog.push_back(mem_addr);
        chk("reqAddr", mem_addr, mFp);
        waitCnt = $urandom_range(0, maxDelay);
      end else begin
        chk("addrHold", mem_addr, prevAddr);
      end
      if (waitCnt == 0) begin ack = 1; dat = mem_addr + 8'h10; end
      else waitCnt--;
    end else if (spur && $urandom_range(0, 7) == 0) begin
      ack = 1; dat = 8'hEE;
    end
    if (!req && mq.size() < D) idleRun++; else idleRun = 0;
    chk("starve", idleRun <= 3, 1);
    prevReq = req; prevAddr = mem_addr;

    LoadIRSig = lp; jump = jmp; jump_addr = ja; mem_ack = ack; mem_data = dat;

    acc = req && ack;
    if (jmp) begin
      mq.delete(); mPc = ja; mFp = ja; mStale = req && !ack; idleRun = 0;
    end else begin
      if (lp && mq.size() > 0) begin
        void'(mq.pop_front()); mPc++; popsSeen++;
      end
      if (acc && !mStale) begin
        chk("noOverflow", mq.size() < D, 1);
        mq.push_back(mFp + 8'h10);
        mFp++;
      end
      if (acc) mStale = 0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit lp; bit jmp; logic [7:0] ja; bit ack; logic [7:0] dat;
    bit eReq; logic [7:0] eAddr; bit eVld; logic [7:0] eInstr; logic [7:0] ePc;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl[NV];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          lp jmp ja     ack dat     req addr   vld instr  pc
    tbl[0]  = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  0, 8'h00, 8'h00};
    tbl[1]  = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  0, 8'h00, 8'h00};
    tbl[2]  = '{0, 0, 8'h00, 0, 8'h00,  1, 8'h00,  0, 8'h00, 8'h00};
    tbl[3]  = '{0, 0, 8'h00, 1, 8'h10,  1, 8'h00,  0, 8'h00, 8'h00};
    tbl[4]  = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  1, 8'h10, 8'h00};
    tbl[5]  = '{0, 0, 8'h00, 0, 8'h00,  1, 8'h01,  1, 8'h10, 8'h00};
    tbl[6]  = '{0, 0, 8'h00, 1, 8'h11,  1, 8'h01,  1, 8'h10, 8'h00};
    tbl[7]  = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  1, 8'h10, 8'h00};
    tbl[8]  = '{1, 0, 8'h00, 0, 8'h00,  0, 8'h00,  1, 8'h10, 8'h00};
    tbl[9]  = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  1, 8'h11, 8'h01};
    tbl[10] = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  1, 8'h11, 8'h01};
    tbl[11] = '{0, 0, 8'h00, 1, 8'h12,  1, 8'h02,  1, 8'h11, 8'h01};
    tbl[12] = '{1, 1, 8'h40, 0, 8'h00,  0, 8'h00,  1, 8'h11, 8'h01};
    tbl[13] = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  0, 8'h00, 8'h40};
    tbl[14] = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  0, 8'h00, 8'h40};
    tbl[15] = '{0, 1, 8'h80, 0, 8'h00,  1, 8'h40,  0, 8'h00, 8'h40};
    tbl[16] = '{0, 0, 8'h00, 1, 8'h50,  1, 8'h40,  0, 8'h00, 8'h80};
    tbl[17] = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  0, 8'h00, 8'h80};
    tbl[18] = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  0, 8'h00, 8'h80};
    tbl[19] = '{1, 0, 8'h00, 1, 8'h90,  1, 8'h80,  0, 8'h00, 8'h80};
    tbl[20] = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  1, 8'h90, 8'h80};
    tbl[21] = '{0, 1, 8'hC0, 1, 8'h91,  1, 8'h81,  1, 8'h90, 8'h80};
    tbl[22] = '{0, 0, 8'h00, 0, 8'h00,  0, 8'h00,  0, 8'h00, 8'hC0};

    popsSeen = 0;
    modelInit();

    // Directed cycle table starting at the reset-release edge.
    doReset();
    for (int i = 0; i < NV; i++) begin
      LoadIRSig = tbl[i].lp; jump = tbl[i].jmp; jump_addr = tbl[i].ja;
      mem_ack = tbl[i].ack; mem_data = tbl[i].dat;
      #1;
      chk($sformatf("t%0d.req", i), mem_req, tbl[i].eReq);
      if (tbl[i].eReq) chk($sformatf("t%0d.addr", i), mem_addr, tbl[i].eAddr);
      chk($sformatf("t%0d.vld", i), instr_valid, tbl[i].eVld);
      chk($sformatf("t%0d.instr", i), instruction, tbl[i].eInstr);
      chk($sformatf("t%0d.pc", i), pc, tbl[i].ePc);
      @(negedge clk);
    end

    // Asynchronous reset pulse while a request is on the bus, then a late ack.
    doReset();
    for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
    chk("rst.reqSeen", mem_req, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst.req", mem_req, 0);
    chk("rst.vld", instr_valid, 0);
    chk("rst.instr", instruction, 8'h00);
    chk("rst.pc", pc, 8'h00);
    chk("rst.addr", mem_addr, 8'h00);
    @(negedge clk);
    reset = 1'b1; mem_ack = 1; mem_data = 8'hAA;
    #1 chk("rel.c0.req", mem_req, 0);
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("rel.c1.req", mem_req, 0);
    chk("rel.c1.vld", instr_valid, 0);
    @(negedge clk);
    #1;
    chk("rel.c2.req", mem_req, 1);
    chk("rel.c2.addr", mem_addr, 8'h00);
    chk("rel.c2.vld", instr_valid, 0);
    @(negedge clk);

    // Address and pc wrap from FE with zero-wait memory and continuous pops.
    doReset();
    modelInit();
    reqLog.delete();
    step(1, 1, 8'hFE, 0, 0);
    repeat (30) step(1, 0, 8'h00, 0, 0);
    chk("wrap.nreq", reqLog.size() >= 4, 1);
    if (reqLog.size() >= 4) begin
      chk("wrap.a0", reqLog[0], 8'hFE);
      chk("wrap.a1", reqLog[1], 8'hFF);
      chk("wrap.a2", reqLog[2], 8'h00);
      chk("wrap.a3", reqLog[3], 8'h01);
    end

    // Random traffic: pops, jumps (often near the wrap point), variable memory latency, stray acks.
    doReset();
    modelInit();
    popsSeen = 0;
    for (int n = 0; n < 3000; n++) begin
      bit lp, jmp;
      logic [7:0] ja;
      lp  = ($urandom % 4) != 0;
      jmp = ($urandom % 40) == 0;
      ja  = (($urandom % 4) == 0) ? 8'(8'hFC + 8'($urandom % 4)) : 8'($urandom);
      step(lp, jmp, ja, 3, 1);
    end
    chk("progress", popsSeen > 300, 1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
